// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: boot/run/halt control, prioritised next-PC
// selection and misaligned-target rejection. Return-address stack built when PC_GEN_RAS_EN is defined.
module pc_gen_unit #(
  parameter int unsigned XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [XLEN-1:0] ResetPc   = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0] IncVal    = XLEN'(INC);
  localparam logic [XLEN-1:0] AlignMask = XLEN'(INC - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_inc;
  logic            trap_ok, redir_ok;
  logic            ras_push, ras_pop, ras_clear;
  logic            ras_nonempty;
  logic [XLEN-1:0] ras_top;

  assign pc_inc   = pc_q + IncVal;
  assign trap_ok  = ((trap_vector & AlignMask) == '0);
  assign redir_ok = ((redirect_target & AlignMask) == '0);

  // Next-state / next-PC selection; halt entry holds the PC of the halting cycle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clear  = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap) begin
          if (trap_ok) begin
            pc_d      = trap_vector;
            ras_clear = 1'b1;
          end else begin
            misalign_d = 1'b1;
          end
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          if (redir_ok) pc_d = redirect_target;
          else          misalign_d = 1'b1;
        end else if (!stall) begin
          ras_pop  = is_ret && ras_nonempty;
          ras_push = is_call;
          pc_d     = ras_pop ? ras_top : pc_inc;
        end
      end
      ST_HALT: begin
        if (trap) begin
          if (trap_ok) begin
            pc_d      = trap_vector;
            ras_clear = 1'b1;
            state_d   = ST_RUN;
          end else begin
            misalign_d = 1'b1;
          end
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= ResetPc;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;
  assign state_o      = state_q;

`ifdef PC_GEN_RAS_EN
  localparam int unsigned    PtrW   = $clog2(RAS_DEPTH);
  localparam int unsigned    CntW   = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ras_ptr_q, ras_ptr_d, ras_top_idx, ras_widx;
  logic [CntW-1:0] ras_cnt_q, ras_cnt_d;
  logic            ras_we;

  assign ras_top_idx  = ras_ptr_q - PtrW'(1);
  assign ras_top      = ras_mem_q[ras_top_idx];
  assign ras_nonempty = (ras_cnt_q != '0);

  // Circular stack: a full push overwrites the oldest entry; call+ret rewrites the top in place
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_widx  = ras_ptr_q;
    if (ras_clear) begin
      ras_ptr_d = '0;
      ras_cnt_d = '0;
    end else if (ras_pop && ras_push) begin
      ras_we   = 1'b1;
      ras_widx = ras_top_idx;
    end else if (ras_pop) begin
      ras_ptr_d = ras_top_idx;
      ras_cnt_d = ras_cnt_q - CntW'(1);
    end else if (ras_push) begin
      ras_we    = 1'b1;
      ras_ptr_d = ras_ptr_q + PtrW'(1);
      if (ras_cnt_q != CntMax) ras_cnt_d = ras_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Entries need no reset: an empty count makes them invisible
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem_q[ras_widx] <= pc_inc;
  end
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras;

  assign ras_nonempty = 1'b0;
  assign ras_top      = '0;
  assign unused_ras   = ras_push ^ ras_pop ^ ras_clear;
`endif

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised next-generation program-counter unit for the RV32 fetch stage.
- Replaces the plain PC register, which loaded PCNext every cycle.
- Internally computes the next PC with a fixed priority: trap > redirect > return prediction > stall hold > sequential increment.
- Adds a boot/run/halt state machine, misalignment detection and an optional return-address stack (RAS). Feeds instruction memory address and the decode-stage PC pipeline.

Parameters:
- XLEN, 32, PC width in bits (32 or 64).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; lower XLEN bits used.
- INC, 4, sequential increment in bytes; 2 or 4.
- RAS_DEPTH, 4, return-address stack entries; power of two, 2..16.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset. Asserts immediately; deassertion is sampled on clk.
- stall, in, 1: hold PC (fetch back-pressure).
- halt_req, in, 1: enter HALT state.
- resume, in, 1: leave HALT state.
- redirect_valid, in, 1: branch/jump resolved taken.
- redirect_target, in, XLEN: redirect destination.
- trap, in, 1: exception/interrupt taken.
- trap_vector, in, XLEN: trap handler address.
- is_call, in, 1: current fetched instruction is a call (push PC+INC).
- is_ret, in, 1: current fetched instruction is a return (pop prediction).
- pc, out, XLEN: current fetch PC.
- pc_valid, out, 1: pc is a valid fetch address this cycle.
- misalign_err, out, 1: one-cycle pulse, rejected misaligned target.
- state_o, out, 2: 00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VECTOR, pc_valid=0, misalign_err=0, state=BOOT.
  - RAS empty: pointer=0, count=0.
  - Reset mid-operation discards all state immediately.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - pc is held; then go to RUN with pc_valid=1 and pc still RESET_VECTOR. First fetch is RESET_VECTOR.
- RUN, next pc per cycle, by priority:
  1. trap=1: pc<=trap_vector; RAS cleared.
  2. redirect_valid=1: pc<=redirect_target.
  3. is_ret=1 and RAS non-empty and !stall: pc<=top entry; pop.
  4. stall=1: pc held; no RAS change.
  5. otherwise: pc<=pc+INC, wrapping modulo 2^XLEN (no flag).
- Trap and redirect override stall.
- is_call with !stall and no trap/redirect: push pc+INC.
  - When the RAS is full, the push overwrites the oldest entry (circular pointer) and count saturates at RAS_DEPTH.
- is_ret with an empty RAS: treated as sequential; no underflow.
- is_call and is_ret together: pop first, then push pc+INC in the same slot (coroutine swap); count unchanged.
- Alignment:
  - Required: target[1:0]==0 if INC=4; target[0]==0 if INC=2.
  - A misaligned trap_vector or redirect_target is rejected: pc held, misalign_err=1 for one cycle, RAS unchanged.
- HALT:
  - Entered from RUN when halt_req=1 and no trap that cycle. A trap takes precedence; halt_req is resampled next cycle.
  - In HALT: pc held, pc_valid=0, redirect/is_call/is_ret ignored.
  - trap in HALT: pc<=trap_vector, go to RUN.
  - resume=1: go to RUN; pc_valid=1 next cycle, same pc.
  - halt_req and resume together in HALT: resume wins.
- Latency: all inputs take effect on pc at the next rising edge (1 cycle). pc is registered with no combinational input-to-output path.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined: RAS instantiated as described; is_call/is_ret active.
- Undefined: no RAS storage; is_call and is_ret ignored; is_ret follows the sequential/stall rules. RAS_DEPTH is unused but legal.

Test Plan:
- Reset and boot: reset=0 for 5 cycles, release.
  - pc=0x0000_0000 with pc_valid=0 for 1 cycle, then pc_valid=1.
  - Next 6 cycles: pc=0x0,0x4,0x8,0xC,0x10,0x14.
- Stall vs redirect: at pc=0x10, stall=1 for 3 cycles → pc stays 0x10. Then stall=1 with redirect_valid=1, target=0x200 → pc=0x200 next cycle.
- Priority and alignment:
  - trap=1, trap_vector=0x100 together with redirect to 0x80 → pc=0x100.
  - redirect_target=0x202 (INC=4) → pc held, misalign_err pulses once.
- RAS (macro defined, RAS_DEPTH=4):
  - is_call at pc=0x40 → pc=0x44. Jump (redirect) to 0x300; is_ret at 0x300 → pc=0x44.
  - Five nested calls, then five returns: first four returns give correct addresses newest-first; fifth return falls through sequentially.
- Halt/resume: halt_req at pc=0x20 → state=HALT, pc_valid=0, pc=0x20 held for 4 cycles. resume=1 → RUN, pc_valid=1, pc=0x20, then 0x24.
- Wrap and async reset: XLEN=32, redirect to 0xFFFF_FFFC → next pc=0x0000_0000. reset pulsed low mid-cycle → pc=RESET_VECTOR immediately, state=BOOT.
